updn_counter: RTL and testbench

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/updn_counter.sv | 83 ++++++++
 tb/tb_updn_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/updn_counter.sv
// Up/down modulo counter with load, cascade enable, terminal count and wrap pulse.
// Optional macro UPDN_COUNTER_OE_EN adds an active-low output enable (OEn) on Q.
module updn_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter int SATURATE = 0
) (
    input  logic             C,
    input  logic             R,
    input  logic             LDn,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CI,
    input  logic             UP,
`ifdef UPDN_COUNTER_OE_EN
    input  logic             OEn,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

    // One extra bit so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH:0]   q_ext, d_ext, inc_ext, dec_ext;
    logic             at_max, at_zero;

    assign q_ext   = {1'b0, q_q};
    assign d_ext   = {1'b0, D};
    assign inc_ext = q_ext + 1'b1;
    assign dec_ext = q_ext - 1'b1;
    assign at_max  = (q_ext == MAX_W);
    assign at_zero = (q_ext == '0);

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!LDn) begin
            q_d = (d_ext >= MOD_W) ? MAX_W[WIDTH-1:0] : D;
        end else if (EN && CI) begin
            if (UP) begin
                if (!at_max) begin
                    q_d = inc_ext[WIDTH-1:0];
                end else if (SATURATE == 0) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_d = dec_ext[WIDTH-1:0];
                end else if (SATURATE == 0) begin
                    q_d    = MAX_W[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Combinational so the next stage's CI sees it in the same cycle.
    assign TC   = EN & CI & (UP ? at_max : at_zero);
    assign WRAP = wrap_q;

`ifdef UPDN_COUNTER_OE_EN
    assign Q = OEn ? {WIDTH{1'bz}} : q_q;
`else
    assign Q = q_q;
`endif

endmodule

// File: tb/tb_updn_counter.sv
// Directed testbench for updn_counter: wrap, saturate, cascade, reset and output-enable cases.
module tb_updn_counter;

    logic C = 1'b0;
    always #5 C = ~C;

    int checks = 0;
    int errors = 0;

    // Wrapping instance (MODULUS=10)
    logic       r_a, ldn_a, en_a, ci_a, up_a;
    logic [3:0] d_a, q_a;
    logic       tc_a, wrap_a;
`ifdef UPDN_COUNTER_OE_EN
    logic       oen_a;
`endif

    // Saturating instance
    logic       r_s, ldn_s, en_s, ci_s, up_s;
    logic [3:0] d_s, q_s;
    logic       tc_s, wrap_s;

    // Cascaded pair
    logic       r_c, ldn_c, en_c, up_c;
    logic [3:0] d_c, q_c1, q_c2;
    logic       tc_c1, tc_c2, wrap_c1, wrap_c2;

    updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .C(C), .R(r_a), .LDn(ldn_a), .D(d_a), .EN(en_a), .CI(ci_a), .UP(up_a),
`ifdef UPDN_COUNTER_OE_EN
        .OEn(oen_a),
`endif
        .Q(q_a), .TC(tc_a), .WRAP(wrap_a)
    );

    updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .C(C), .R(r_s), .LDn(ldn_s), .D(d_s), .EN(en_s), .CI(ci_s), .UP(up_s),
`ifdef UPDN_COUNTER_OE_EN
        .OEn(1'b0),
`endif
        .Q(q_s), .TC(tc_s), .WRAP(wrap_s)
    );

    updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c1 (
        .C(C), .R(r_c), .LDn(ldn_c), .D(d_c), .EN(en_c), .CI(1'b1), .UP(up_c),
`ifdef UPDN_COUNTER_OE_EN
        .OEn(1'b0),
`endif
        .Q(q_c1), .TC(tc_c1), .WRAP(wrap_c1)
    );

    updn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_c2 (
        .C(C), .R(r_c), .LDn(ldn_c), .D(d_c), .EN(en_c), .CI(tc_c1), .UP(up_c),
`ifdef UPDN_COUNTER_OE_EN
        .OEn(1'b0),
`endif
        .Q(q_c2), .TC(tc_c2), .WRAP(wrap_c2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("pass %s value=%0h", tag, obs);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge C);
        #1;
    endtask

    initial begin
        r_a = 1'b1; ldn_a = 1'b1; d_a = 4'd0; en_a = 1'b1; ci_a = 1'b1; up_a = 1'b0;
`ifdef UPDN_COUNTER_OE_EN
        oen_a = 1'b0;
`endif
        r_s = 1'b1; ldn_s = 1'b0; d_s = 4'd8; en_s = 1'b1; ci_s = 1'b1; up_s = 1'b1;
        r_c = 1'b1; ldn_c = 1'b1; d_c = 4'd0; en_c = 1'b1; up_c = 1'b1;

        // Reset state
        #1;
        check("rst_q", 32'(q_a), 32'd0);
        check("rst_wrap", 32'(wrap_a), 32'd0);
        check("rst_tc_down", 32'(tc_a), 32'd1);
        up_a = 1'b1;
        #1;
        check("rst_tc_up", 32'(tc_a), 32'd0);
        r_a = 1'b0;
        r_s = 1'b0;

        // Count up through the wrap
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("up%0d_q", i), 32'(q_a), 32'(i % 10));
            check($sformatf("up%0d_tc", i), 32'(tc_a), 32'((i % 10) == 9));
            check($sformatf("up%0d_wrap", i), 32'(wrap_a), 32'(i == 10));
        end

        // Clamped load then count down through the wrap
        ldn_a = 1'b0; d_a = 4'd13;
        tick();
        check("ld13_q", 32'(q_a), 32'd9);
        check("ld13_wrap", 32'(wrap_a), 32'd0);
        ldn_a = 1'b1; up_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("dn%0d_q", k), 32'(q_a), 32'((k <= 9) ? (9 - k) : 9));
            check($sformatf("dn%0d_tc", k), 32'(tc_a), 32'(k == 9));
            check($sformatf("dn%0d_wrap", k), 32'(wrap_a), 32'(k == 10));
        end

        // Direction change is seen on TC at once; load beats a pending wrap
        up_a = 1'b1;
        #1;
        check("dir_tc", 32'(tc_a), 32'd1);
        ldn_a = 1'b0; d_a = 4'd5;
        tick();
        check("ldpri_q", 32'(q_a), 32'd5);
        check("ldpri_wrap", 32'(wrap_a), 32'd0);

        // Hold on EN=0 and on CI=0
        ldn_a = 1'b1; en_a = 1'b0;
        tick();
        check("hold_en_q", 32'(q_a), 32'd5);
        check("hold_en_tc", 32'(tc_a), 32'd0);
        en_a = 1'b1; ci_a = 1'b0;
        tick();
        check("hold_ci_q", 32'(q_a), 32'd5);
        ci_a = 1'b1;

        // Async reset pulse between edges during a pending load
        ldn_a = 1'b0; d_a = 4'd6;
        tick();
        check("ld6_q", 32'(q_a), 32'd6);
        d_a = 4'd3;
        r_a = 1'b1;
        #1;
        check("rpulse_q", 32'(q_a), 32'd0);
        check("rpulse_wrap", 32'(wrap_a), 32'd0);
        #1;
        r_a = 1'b0;
        tick();
        check("after_rel_q", 32'(q_a), 32'd3);
        r_a = 1'b1;
        tick();
        check("rhold_q", 32'(q_a), 32'd0);
        r_a = 1'b0;
        ldn_a = 1'b1;

`ifdef UPDN_COUNTER_OE_EN
        oen_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("oe%0d_q", i), {28'd0, q_a}, {28'd0, 4'bzzzz});
            check($sformatf("oe%0d_tc", i), 32'(tc_a), 32'd0);
        end
        oen_a = 1'b0;
        #1;
        check("oe_on_q", 32'(q_a), 32'd4);
`endif

        // Saturating instance: load 8, then hold at the top and bottom
        tick();
        check("sat_ld_q", 32'(q_s), 32'd8);
        ldn_s = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("satup%0d_q", i), 32'(q_s), 32'd9);
            check($sformatf("satup%0d_wrap", i), 32'(wrap_s), 32'd0);
            check($sformatf("satup%0d_tc", i), 32'(tc_s), 32'd1);
        end
        ldn_s = 1'b0; d_s = 4'd0;
        tick();
        ldn_s = 1'b1; up_s = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("satdn%0d_q", i), 32'(q_s), 32'd0);
            check($sformatf("satdn%0d_wrap", i), 32'(wrap_s), 32'd0);
            check($sformatf("satdn%0d_tc", i), 32'(tc_s), 32'd1);
        end

        // Cascaded decade pair: 25 edges from reset
        r_c = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            tick();
            check($sformatf("casc%0d_q1", n), 32'(q_c1), 32'(n % 10));
            check($sformatf("casc%0d_q2", n), 32'(q_c2), 32'((n / 10) % 10));
        end
        check("casc_final", {24'd0, q_c2, q_c1}, 32'h25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
